// File: rtl/uart_txd_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_txd_arb_if
// Brief    : Request/grant and byte-level TX handshake bundle for uart_txd_arb.
// Revision : 1.0
// ============================================================================
interface uart_txd_arb_if;
    logic        req0;
    logic [23:0] payload0;
    logic        req1;
    logic [23:0] payload1;
    logic        grant0;
    logic        grant1;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        busy;
    logic        frame_done;
    logic        err;

    // Environment side: requesters plus the UART TX core.
    modport master (
        output req0, payload0, req1, payload1, tx_done,
        input  grant0, grant1, tx_start, tx_data, busy, frame_done, err
    );

    // Arbiter side.
    modport slave (
        input  req0, payload0, req1, payload1, tx_done,
        output grant0, grant1, tx_start, tx_data, busy, frame_done, err
    );
endinterface
`default_nettype wire

// File: rtl/uart_txd_arb.sv
`default_nettype none
// ============================================================================
// Module   : uart_txd_arb
// Brief    : Round-robin sharing of one UART TX between two requesters, each
//            grant sent as an 8-byte frame FF F0 A0 p2 p1 p0 0D 0A.
// Revision : 1.0
// ============================================================================
module uart_txd_arb #(
    parameter int TIMEOUT = 100000,
    parameter int TMO_W   = 17
) (
    input  logic          clk,
    input  logic          rst,
    uart_txd_arb_if.slave bus
);

    localparam logic [7:0]       c_SYNC0   = 8'hFF;
    localparam logic [7:0]       c_SYNC1   = 8'hF0;
    localparam logic [7:0]       c_SYNC2   = 8'hA0;
    localparam logic [7:0]       c_CR      = 8'h0D;
    localparam logic [7:0]       c_LF      = 8'h0A;
    localparam logic [2:0]       c_LAST    = 3'd7;
    localparam logic [TMO_W-1:0] c_TIMEOUT = TMO_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [2:0]       r_idx;
    logic [TMO_W-1:0] r_wdog;
    logic             r_last_grant;
    logic [23:0]      r_payload;
    logic             r_grant0;
    logic             r_grant1;
    logic             r_tx_start;
    logic [7:0]       r_tx_data;
    logic             r_busy;
    logic             r_frame_done;
    logic             r_err;

    state_t           w_state_nxt;
    logic [2:0]       w_idx_nxt;
    logic [TMO_W-1:0] w_wdog_nxt;
    logic             w_last_nxt;
    logic [23:0]      w_payload_nxt;
    logic             w_grant0_nxt;
    logic             w_grant1_nxt;
    logic             w_tx_start_nxt;
    logic [7:0]       w_tx_data_nxt;
    logic             w_busy_nxt;
    logic             w_frame_done_nxt;
    logic             w_err_nxt;

    logic             w_pick0;
    logic             w_pick1;
    logic [2:0]       w_idx_inc;
    logic [TMO_W-1:0] w_wdog_inc;

    function automatic logic [7:0] f_frame_byte(input logic [2:0] idx,
                                                input logic [23:0] pl);
        logic [7:0] b;
        case (idx)
            3'd0:    b = c_SYNC0;
            3'd1:    b = c_SYNC1;
            3'd2:    b = c_SYNC2;
            3'd3:    b = pl[23:16];
            3'd4:    b = pl[15:8];
            3'd5:    b = pl[7:0];
            3'd6:    b = c_CR;
            default: b = c_LF;
        endcase
        return b;
    endfunction

    // On a tie the requester that did not win last time is served.
    assign w_pick0    = bus.req0 & (~bus.req1 | r_last_grant);
    assign w_pick1    = bus.req1 & ~w_pick0;
    assign w_idx_inc  = r_idx + 3'd1;
    assign w_wdog_inc = r_wdog + TMO_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_idx        <= 3'd0;
            r_wdog       <= '0;
            r_last_grant <= 1'b1;
            r_payload    <= 24'h000000;
            r_grant0     <= 1'b0;
            r_grant1     <= 1'b0;
            r_tx_start   <= 1'b0;
            r_tx_data    <= 8'h00;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_wdog       <= w_wdog_nxt;
            r_last_grant <= w_last_nxt;
            r_payload    <= w_payload_nxt;
            r_grant0     <= w_grant0_nxt;
            r_grant1     <= w_grant1_nxt;
            r_tx_start   <= w_tx_start_nxt;
            r_tx_data    <= w_tx_data_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_err        <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_idx_nxt        = r_idx;
        w_wdog_nxt       = r_wdog;
        w_last_nxt       = r_last_grant;
        w_payload_nxt    = r_payload;
        w_grant0_nxt     = 1'b0;
        w_grant1_nxt     = 1'b0;
        w_tx_start_nxt   = 1'b0;
        w_tx_data_nxt    = r_tx_data;
        w_busy_nxt       = r_busy;
        w_frame_done_nxt = 1'b0;
        w_err_nxt        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_pick0 || w_pick1) begin
                    w_grant0_nxt   = w_pick0;
                    w_grant1_nxt   = w_pick1;
                    w_last_nxt     = w_pick1;
                    w_payload_nxt  = w_pick0 ? bus.payload0 : bus.payload1;
                    w_idx_nxt      = 3'd0;
                    w_wdog_nxt     = '0;
                    w_tx_start_nxt = 1'b1;
                    w_tx_data_nxt  = f_frame_byte(3'd0, w_payload_nxt);
                    w_busy_nxt     = 1'b1;
                    w_state_nxt    = S_WAIT;
                end
            end

            S_WAIT: begin
                // A completion in the expiry cycle still counts as on time.
                if (bus.tx_done) begin
                    if (r_idx == c_LAST) begin
                        w_frame_done_nxt = 1'b1;
                        w_state_nxt      = S_DONE;
                    end else begin
                        w_idx_nxt      = w_idx_inc;
                        w_tx_start_nxt = 1'b1;
                        w_tx_data_nxt  = f_frame_byte(w_idx_inc, r_payload);
                        w_wdog_nxt     = '0;
                    end
                end else if (w_wdog_inc == c_TIMEOUT) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_wdog_nxt = w_wdog_inc;
                end
            end

            S_DONE: begin
                w_busy_nxt  = 1'b0;
                w_idx_nxt   = 3'd0;
                w_wdog_nxt  = '0;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.grant0     = r_grant0;
    assign bus.grant1     = r_grant1;
    assign bus.tx_start   = r_tx_start;
    assign bus.tx_data    = r_tx_data;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;
    assign bus.err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_txd_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_txd_arb
// Brief    : Self-checking bench for uart_txd_arb against a queue-based frame model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_uart_txd_arb;

    localparam int TB_TIMEOUT = 50;
    localparam int TB_TMO_W   = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_txd_arb_if bus();

    logic resp_done = 1'b0;
    logic spur_done = 1'b0;
    assign bus.tx_done = resp_done | spur_done;

    uart_txd_arb #(
        .TIMEOUT (TB_TIMEOUT),
        .TMO_W   (TB_TMO_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit cmp_en  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Frame model: bytes still to send are a queue built at grant time.
    logic [7:0]  m_q[$];
    bit          m_active, m_tail, m_last;
    int          m_since;
    bit          m_g0, m_g1;
    logic [23:0] m_p;
    logic        exp_g0, exp_g1, exp_st, exp_busy, exp_fd, exp_err;
    logic [7:0]  exp_data;

    always @(posedge clk) begin
        exp_g0 = 1'b0; exp_g1 = 1'b0; exp_st = 1'b0; exp_fd = 1'b0; exp_err = 1'b0;
        if (rst) begin
            m_active = 1'b0; m_tail = 1'b0; m_last = 1'b1; m_since = 0;
            m_q.delete();
            exp_data = 8'h00; exp_busy = 1'b0;
        end else if (m_tail) begin
            m_tail = 1'b0;
            exp_busy = 1'b0;
        end else if (m_active) begin
            if (bus.tx_done) begin
                if (m_q.size() == 0) begin
                    exp_fd = 1'b1; m_active = 1'b0; m_tail = 1'b1;
                end else begin
                    exp_st = 1'b1; exp_data = m_q.pop_front(); m_since = 0;
                end
            end else begin
                m_since++;
                if (m_since >= TB_TIMEOUT) begin
                    exp_err = 1'b1; m_active = 1'b0; m_tail = 1'b1;
                end
            end
        end else begin
            m_g0 = bus.req0 && (!bus.req1 || m_last);
            m_g1 = bus.req1 && !m_g0;
            if (m_g0 || m_g1) begin
                m_p = m_g0 ? bus.payload0 : bus.payload1;
                m_last = m_g1;
                m_q = {8'hF0, 8'hA0, m_p[23:16], m_p[15:8], m_p[7:0], 8'h0D, 8'h0A};
                exp_g0 = m_g0; exp_g1 = m_g1;
                exp_st = 1'b1; exp_data = 8'hFF; exp_busy = 1'b1;
                m_active = 1'b1; m_since = 0;
            end
        end
    end

    logic [7:0] tx_log[$];
    int         start_cyc_log[$];
    bit         grant_log[$];
    int         n_starts = 0, n_fd = 0, n_err = 0, grant_cyc = -1, err_cyc = -1;

    always @(negedge clk) begin
        if (cmp_en) begin
            n_tests++;
            if ({bus.grant0, bus.grant1, bus.tx_start, bus.tx_data, bus.busy, bus.frame_done, bus.err}
                !== {exp_g0, exp_g1, exp_st, exp_data, exp_busy, exp_fd, exp_err}) begin
                n_fail++;
                $display("FAIL outputs cyc=%0d got g0/g1/st/data/busy/fd/err=%b/%b/%b/%h/%b/%b/%b want %b/%b/%b/%h/%b/%b/%b",
                         cyc, bus.grant0, bus.grant1, bus.tx_start, bus.tx_data, bus.busy, bus.frame_done, bus.err,
                         exp_g0, exp_g1, exp_st, exp_data, exp_busy, exp_fd, exp_err);
            end
            if (bus.tx_start) begin
                n_starts++; tx_log.push_back(bus.tx_data); start_cyc_log.push_back(cyc);
            end
            if (bus.grant0 || bus.grant1) begin
                grant_log.push_back(bus.grant1); grant_cyc = cyc;
            end
            if (bus.frame_done) n_fd++;
            if (bus.err) begin n_err++; err_cyc = cyc; end
        end
    end

    // UART core stand-in: answers each start after resp_delay cycles unless stalled.
    int         resp_delay    = 10;
    bit         resp_stall_en = 1'b0;
    logic [7:0] resp_stall_byte = 8'hA0;
    int         r_cnt = 0;

    always @(negedge clk) begin
        resp_done = 1'b0;
        if (r_cnt == 1) begin
            resp_done = 1'b1; r_cnt = 0;
        end else if (r_cnt > 1) begin
            r_cnt--;
        end
        if (bus.tx_start === 1'b1 && !(resp_stall_en && bus.tx_data == resp_stall_byte))
            r_cnt = resp_delay;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic wait_grant(input string name);
        int k;
        k = 0;
        while (!(bus.grant0 || bus.grant1) && k < 60) begin tick(); k++; end
        check(name, 32'(bus.grant0 | bus.grant1), 32'd1);
    endtask

    task automatic wait_fd(input string name, input int target, input int budget);
        int k;
        k = 0;
        while (n_fd < target && k < budget) begin tick(); k++; end
        check(name, n_fd, target);
    endtask

    logic [7:0]  exp_single[8];
    logic [23:0] p0, p1;
    int          c0, base_tx, base_st, base_fd, base_err, base_g, k;

    initial begin
        exp_single = '{8'hFF, 8'hF0, 8'hA0, 8'h7C, 8'h12, 8'h34, 8'h0D, 8'h0A};
        rst = 1'b1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.payload0 = 24'h0; bus.payload1 = 24'h0;
        @(posedge clk);
        #1 cmp_en = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("reset_outputs", 32'({bus.grant0, bus.grant1, bus.tx_start, bus.tx_data,
                                    bus.busy, bus.frame_done, bus.err}), 32'd0);

        // Single request, payload changed right after grant.
        base_tx = tx_log.size(); base_st = n_starts; base_fd = n_fd;
        bus.payload0 = 24'h7C1234;
        bus.req0 = 1'b1;
        c0 = cyc;
        wait_grant("single_grant");
        check("single_grant_cycle", grant_cyc, c0 + 1);
        check("single_grant0", 32'(bus.grant0), 32'd1);
        bus.req0 = 1'b0;
        bus.payload0 = 24'hDEADBE;
        wait_fd("single_frame_done", base_fd + 1, 200);
        check("single_starts", n_starts - base_st, 8);
        if (tx_log.size() >= base_tx + 8)
            for (int i = 0; i < 8; i++)
                check($sformatf("single_byte%0d", i), 32'(tx_log[base_tx + i]), 32'(exp_single[i]));
        repeat (5) tick();
        check("single_one_fd", n_fd - base_fd, 1);

        // Spurious tx_done while idle.
        base_st = n_starts;
        for (int i = 0; i < 4; i++) begin
            spur_done = 1'b1; tick(); spur_done = 1'b0; tick();
        end
        check("spurious_no_start", n_starts - base_st, 0);

        // Round robin from reset with both requests held.
        do_reset();
        base_g = grant_log.size(); base_tx = tx_log.size(); base_fd = n_fd;
        p0 = 24'($urandom); p1 = 24'($urandom);
        bus.payload0 = p0; bus.payload1 = p1;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        wait_fd("rr_four_frames", base_fd + 4, 600);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        repeat (5) tick();
        check("rr_grant_count", grant_log.size() - base_g, 4);
        if (grant_log.size() >= base_g + 4 && tx_log.size() >= base_tx + 32)
            for (int i = 0; i < 4; i++) begin
                check($sformatf("rr_grant%0d", i), 32'(grant_log[base_g + i]), 32'(i % 2));
                check($sformatf("rr_payload%0d", i),
                      32'({tx_log[base_tx + 8*i + 3], tx_log[base_tx + 8*i + 4], tx_log[base_tx + 8*i + 5]}),
                      32'((i % 2 == 0) ? p0 : p1));
            end

        // tx_done landing exactly on the expiry cycle for every byte.
        do_reset();
        base_fd = n_fd; base_err = n_err; base_st = n_starts;
        resp_delay = TB_TIMEOUT - 1;
        bus.payload1 = 24'($urandom);
        bus.req1 = 1'b1;
        wait_grant("edge_grant");
        bus.req1 = 1'b0;
        wait_fd("edge_frame_done", base_fd + 1, 8 * TB_TIMEOUT + 50);
        check("edge_no_err", n_err - base_err, 0);
        if (start_cyc_log.size() >= base_st + 2)
            check("edge_start_spacing", start_cyc_log[base_st + 1] - start_cyc_log[base_st], TB_TIMEOUT);
        resp_delay = 10;

        // Stalled transmitter after A0, req1 pending.
        do_reset();
        base_fd = n_fd; base_err = n_err; base_st = n_starts; base_tx = tx_log.size();
        resp_stall_en = 1'b1;
        bus.payload0 = 24'h112233; bus.payload1 = 24'h445566;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        wait_grant("stall_grant");
        check("stall_grant0_first", 32'(bus.grant0), 32'd1);
        bus.req0 = 1'b0;
        k = 0;
        while (n_err == base_err && k < 300) begin tick(); k++; end
        resp_stall_en = 1'b0;
        check("stall_err_seen", n_err - base_err, 1);
        check("stall_starts", n_starts - base_st, 3);
        check("stall_no_fd", n_fd - base_fd, 0);
        if (start_cyc_log.size() >= base_st + 3) begin
            check("stall_third_byte", 32'(tx_log[base_tx + 2]), 32'hA0);
            check("stall_err_delay", err_cyc - start_cyc_log[base_st + 2], TB_TIMEOUT);
        end
        tick();
        check("stall_busy_low", 32'(bus.busy), 32'd0);
        tick();
        check("stall_next_grant1", 32'(bus.grant1), 32'd1);
        bus.req1 = 1'b0;
        wait_fd("stall_next_frame", base_fd + 1, 200);

        // Reset during byte 5.
        do_reset();
        base_fd = n_fd; base_err = n_err; base_st = n_starts;
        bus.payload0 = 24'hA5B6C7;
        bus.req0 = 1'b1;
        wait_grant("rst_grant");
        bus.req0 = 1'b0;
        k = 0;
        while (n_starts - base_st < 5 && k < 200) begin tick(); k++; end
        check("rst_reached_byte5", n_starts - base_st, 5);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_outputs", 32'({bus.grant0, bus.grant1, bus.tx_start, bus.tx_data,
                                  bus.busy, bus.frame_done, bus.err}), 32'd0);
        base_st = n_starts;
        repeat (40) tick();
        check("rst_no_start", n_starts - base_st, 0);
        check("rst_no_fd", n_fd - base_fd, 0);
        check("rst_no_err", n_err - base_err, 0);
        base_tx = tx_log.size();
        bus.payload0 = 24'($urandom);
        bus.req0 = 1'b1;
        wait_grant("rst_regrant");
        bus.req0 = 1'b0;
        if (tx_log.size() > base_tx)
            check("rst_fresh_ff", 32'(tx_log[base_tx]), 32'hFF);
        else
            check("rst_fresh_start", tx_log.size() - base_tx, 1);
        wait_fd("rst_fresh_frame", base_fd + 1, 200);

        // Randomized traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) bus.req0 = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) bus.req1 = 1'($urandom_range(0, 1));
            bus.payload0 = 24'($urandom);
            bus.payload1 = 24'($urandom);
            resp_delay = ($urandom_range(0, 15) == 0) ? int'($urandom_range(40, 60))
                                                      : int'($urandom_range(1, 12));
            spur_done = ($urandom_range(0, 60) == 0);
            tick();
        end
        spur_done = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        repeat (150) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
